// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and helpers for the multiply/divide unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int CNT_W = 16;

    // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_counter.sv
// rtl/md_counter.sv - loadable down-counter with zero flag for operation latency
module md_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        md_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic        cnt_zero;
    logic        accept_md, accept_mt, commit;
    logic        op_signed, op_div, neg_res, neg_rem;
    logic [31:0] ua, ub, quo_mag, rem_mag, quo, rem;
    logic [63:0] prod_mag, prod;
    logic [CNT_W-1:0] load_val;

    assign accept_md = (state_q == IDLE) && start && !flush && !md_op[2];
    assign accept_mt = (state_q == IDLE) && start && !flush &&
                       ((md_op == MD_MTHI) || (md_op == MD_MTLO));
    // Counter is loaded with N-1 so the commit edge lands exactly N edges after acceptance.
    assign commit    = (state_q == RUN) && !flush && cnt_zero;
    assign load_val  = md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    md_counter #(.W(CNT_W)) u_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (flush),
        .load_i     (accept_md),
        .load_val_i (load_val),
        .dec_i      (state_q == RUN),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_md) state_d = RUN;
            RUN:  if (flush || cnt_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN);
        stall = busy || (start && !md_op[2]);
    end

    // Arithmetic on magnitudes, then sign restored: avoids signed-overflow corner cases.
    always_comb begin
        op_signed = !md_op[0];
        op_div    = md_op[1];
        ua        = md_abs(a, op_signed);
        ub        = md_abs(b, op_signed);
        neg_res   = op_signed && (a[31] ^ b[31]);
        neg_rem   = op_signed && a[31];
        prod_mag  = {32'd0, ua} * {32'd0, ub};
        quo_mag   = (ub == 32'd0) ? 32'd0 : (ua / ub);
        rem_mag   = (ub == 32'd0) ? 32'd0 : (ua % ub);
        prod      = neg_res ? (~prod_mag + 64'd1) : prod_mag;
        quo       = neg_res ? (~quo_mag + 32'd1) : quo_mag;
        rem       = neg_rem ? (~rem_mag + 32'd1) : rem_mag;
        pend_hi_d = op_div ? rem : prod[63:32];
        pend_lo_d = op_div ? quo : prod[31:0];
        pend_we_d = !(op_div && (b == 32'd0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else if (accept_md) begin
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit && pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (accept_mt) begin
            if (md_op == MD_MTHI) begin
                hi_d = a;
            end else begin
                lo_d = a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = md_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a 64-bit arithmetic model
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        md_sel = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall;
    logic [31:0] hi, lo, md_out;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .md_sel (md_sel),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        md_sel = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_hi"}, hi, mhi);
        chk({tag, "_lo"}, lo, mlo);
        chk({tag, "_md_out"}, md_out, md_sel ? mhi : mlo);
    endtask

    // Architectural effect of one completed operation, using wide signed arithmetic.
    function automatic void ref_apply(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'd0: begin p = sx * sy; mhi = p[63:32]; mlo = p[31:0]; end
            3'd1: begin u = {32'd0, x} * {32'd0, y}; mhi = u[63:32]; mlo = u[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; mlo = q[31:0]; mhi = r[31:0]; end
            3'd3: if (y != 0) begin mlo = x / y; mhi = x % y; end
            3'd4: mhi = x;
            3'd5: mlo = x;
            default: ;
        endcase
    endfunction

    task automatic run_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int n;
        n = op[1] ? DC : MC;
        start = 1'b1; md_op = op; a = x; b = y;
        #1;
        chk("stall_start", {31'd0, stall}, 32'd1);
        tick;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("stall_run", {31'd0, stall}, 32'd1);
            tick;
        end
        ref_apply(op, x, y);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk_regs("md_result");
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
        start = 1'b1; md_op = op; a = x; b = $urandom;
        #1;
        chk("stall_mt", {31'd0, stall}, 32'd0);
        tick;
        start = 1'b0;
        ref_apply(op, x, 32'd0);
        chk("busy_mt", {31'd0, busy}, 32'd0);
        chk_regs("mt_result");
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tick;
        tick;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk_regs("reset");
        reset = 1'b1;
        tick;

        run_md(3'd0, 32'hFFFFFFFF, 32'd2);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        run_md(3'd1, 32'hFFFFFFFF, 32'd2);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        run_md(3'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_md(3'd3, 32'd7, 32'd2);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        run_mt(3'd4, 32'h12345678);
        run_mt(3'd5, 32'h9ABCDEF0);
        md_sel = 1'b1; #1;
        chk("mfhi", md_out, 32'h12345678);
        md_sel = 1'b0; #1;
        chk("mflo", md_out, 32'h9ABCDEF0);

        run_mt(3'd4, 32'h000000AA);
        run_mt(3'd5, 32'h00000055);
        run_md(3'd2, 32'h00001234, 32'd0);
        chk("divz_hi", hi, 32'h000000AA);
        chk("divz_lo", lo, 32'h00000055);
        run_md(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);

        // Flush two cycles into a MULT: no commit now or later.
        start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
        tick;
        start = 1'b0;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk_regs("flush");
        for (int k = 0; k < MC; k++) tick;
        chk_regs("flush_late");

        start = 1'b1; md_op = 3'd0; a = 32'd9; b = 32'd9; flush = 1'b1;
        #1;
        chk("flush_start_stall", {31'd0, stall}, 32'd1);
        tick;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        chk_regs("flush_start");

        // MTLO offered while a MULT is running must be dropped.
        start = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd6;
        tick;
        md_op = 3'd5; a = 32'hDEADBEEF;
        #1;
        chk("mt_in_run_stall", {31'd0, stall}, 32'd1);
        tick;
        start = 1'b0;
        for (int k = 0; k < MC - 1; k++) begin
            chk("mt_in_run_busy", {31'd0, busy}, 32'd1);
            tick;
        end
        ref_apply(3'd0, 32'd5, 32'd6);
        chk("mt_in_run_done", {31'd0, busy}, 32'd0);
        chk_regs("mt_in_run");

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        mhi = 32'd0; mlo = 32'd0;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_hi", hi, 32'd0);
        chk("areset_lo", lo, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < DC; k++) tick;
        chk("areset_late_busy", {31'd0, busy}, 32'd0);
        chk_regs("areset_late");

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if (rop[2]) run_mt(rop, ra);
            else run_md(rop, ra, rb);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
